// File: rtl/aes_bist_pkg.sv
// aes_bist_pkg: shared constants and FSM state type for the AES BIST.
// No ports; imported by aes_bist and aes_bist_lfsr.
package aes_bist_pkg;

  localparam logic [127:0] BIST_LFSR_POLY = 128'h87;
  localparam logic [15:0]  BIST_IDX_NONE  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ENC,
    S_WAIT_DEC,
    S_CHECK,
    S_DONE,
    S_ERROR
  } bist_state_t;

endpackage

// File: rtl/aes_bist_if.sv
// aes_bist_if: BIST <-> cipher/inverse-cipher bundle.
// master = BIST (drives plaintext/enable), slave = cipher pair.
interface aes_bist_if;

  logic [127:0] enc_data_o;
  logic         enc_en_o;
  logic         enc_ready_i;
  logic [127:0] enc_data_i;
  logic         dec_ready_i;
  logic [127:0] dec_data_i;

  modport master (
    output enc_data_o, enc_en_o,
    input  enc_ready_i, enc_data_i,
    input  dec_ready_i, dec_data_i
  );

  modport slave (
    input  enc_data_o, enc_en_o,
    output enc_ready_i, enc_data_i,
    output dec_ready_i, dec_data_i
  );

endinterface

// File: rtl/aes_bist_lfsr.sv
// aes_bist_lfsr: one Galois step, x^128+x^7+x^2+x+1, shift left.
// Ports: cur (current state), nxt (next state); purely combinational.
module aes_bist_lfsr
  import aes_bist_pkg::*;
(
  input  logic [127:0] cur,
  output logic [127:0] nxt
);

  assign nxt = {cur[126:0], 1'b0}
             ^ (cur[127] ? BIST_LFSR_POLY : '0);

endmodule

// File: rtl/aes_bist.sv
// aes_bist: round-trip self-test of the AES cipher/inverse pair.
// Ports: clk, rst (async, active-low), start, cif (cipher bus), status.
module aes_bist
  import aes_bist_pkg::*;
#(
  parameter int           NVEC    = 4,
  parameter logic [127:0] SEED    =
    128'h00112233445566778899aabbccddeeff,
  parameter bit           KAT_EN  = 1'b1,
  parameter logic [127:0] KAT_CT  =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
  parameter int           TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  aes_bist_if.master  cif,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        kat_fail_o,
  output logic        timeout_o,
  output logic [15:0] fail_cnt_o,
  output logic [15:0] fail_idx_o,
  output logic [15:0] vec_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  bist_state_t    state, nxt;
  logic [127:0]   lfsr, lfsr_nxt;
  logic [127:0]   pt_q, dec_q;
  logic [TW-1:0]  timer;
  logic           tmo, last, go;

  aes_bist_lfsr u_lfsr (
    .cur (lfsr),
    .nxt (lfsr_nxt)
  );

  assign tmo  = (timer == TW'(TIMEOUT - 1));
  assign last = ({1'b0, vec_cnt_o} + 17'd1)
             == 17'(NVEC);
  assign go   = start & ((state == S_IDLE)
              | (state == S_DONE)
              | (state == S_ERROR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) nxt = S_LOAD;
      S_LOAD:
        nxt = S_WAIT_ENC;
      S_WAIT_ENC:
        if (cif.enc_ready_i) nxt = S_WAIT_DEC;
        else if (tmo)        nxt = S_ERROR;
      S_WAIT_DEC:
        if (cif.dec_ready_i) nxt = S_CHECK;
        else if (tmo)        nxt = S_ERROR;
      S_CHECK:
        nxt = last ? S_DONE : S_LOAD;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr       <= SEED;
      pt_q       <= '0;
      dec_q      <= '0;
      timer      <= '0;
      kat_fail_o <= 1'b0;
      timeout_o  <= 1'b0;
      fail_cnt_o <= '0;
      fail_idx_o <= BIST_IDX_NONE;
      vec_cnt_o  <= '0;
    end else begin
      // timer restarts on every wait-state entry
      if (state != nxt)
        timer <= '0;
      else if ((state == S_WAIT_ENC)
            || (state == S_WAIT_DEC))
        timer <= timer + 1'b1;

      if (go) begin
        lfsr       <= SEED;
        pt_q       <= SEED;
        kat_fail_o <= 1'b0;
        timeout_o  <= 1'b0;
        fail_cnt_o <= '0;
        fail_idx_o <= BIST_IDX_NONE;
        vec_cnt_o  <= '0;
      end

      if ((state == S_WAIT_ENC)
          && cif.enc_ready_i
          && KAT_EN
          && (vec_cnt_o == '0)
          && (cif.enc_data_i != KAT_CT))
        kat_fail_o <= 1'b1;

      if ((state == S_WAIT_DEC) && cif.dec_ready_i)
        dec_q <= cif.dec_data_i;

      if (nxt == S_ERROR && state != S_ERROR)
        timeout_o <= 1'b1;

      if (state == S_CHECK) begin
        if (dec_q != pt_q) begin
          if (fail_cnt_o != 16'hFFFF)
            fail_cnt_o <= fail_cnt_o + 1'b1;
          if (fail_idx_o == BIST_IDX_NONE)
            fail_idx_o <= vec_cnt_o;
        end
        vec_cnt_o <= vec_cnt_o + 1'b1;
        lfsr      <= lfsr_nxt;
        // plaintext changes only as the next LOAD begins
        if (!last) pt_q <= lfsr_nxt;
      end
    end
  end

  assign cif.enc_data_o = pt_q;
  assign cif.enc_en_o   = (state == S_LOAD);

  assign busy_o = (state == S_LOAD)
               || (state == S_WAIT_ENC)
               || (state == S_WAIT_DEC)
               || (state == S_CHECK);
  assign done_o = (state == S_DONE)
               || (state == S_ERROR);
  assign pass_o = (state == S_DONE)
               && (fail_cnt_o == '0)
               && !kat_fail_o;

endmodule

// File: doc/aes_bist.md
Name: aes_bist

Overview:
- Parametrised built-in self-test controller for the AES datapath. Drives NVEC pseudo-random 128-bit blocks through the cipher, observes the chained inverse cipher and checks each round trip.
- Optionally checks the first ciphertext against a known-answer vector.
- Reports pass/fail, mismatch count, first failing index and timeout status.
- Sits beside aes_cipher/aes_icipher in the top level. The key is driven by the parent, not by this block.

Parameters:
- NVEC, 4, number of vectors per run (1..65535).
- SEED, 128'h00112233445566778899aabbccddeeff, LFSR seed and vector 0 plaintext.
- KAT_EN, 1, enable known-answer check on vector 0.
- KAT_CT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, expected vector 0 ciphertext.
- TIMEOUT, 256, max cycles per wait state before abort.

Ports:
- rst  input  1  reset; asynchronous, active-low
- clk  input  1  clock
- start  input  1  level; run begins on a cycle where start=1 in IDLE or DONE
- enc_data_o  output  128  plaintext to cipher Data_in (byte 0 = bits [127:120])
- enc_en_o  output  1  cipher Enable
- enc_ready_i  input  1  cipher Ready_out
- enc_data_i  input  128  cipher Data_out
- dec_ready_i  input  1  inverse cipher Ready_out
- dec_data_i  input  128  inverse cipher Data_out
- busy_o  output  1  run in progress
- done_o  output  1  run finished (sticky until next start)
- pass_o  output  1  valid with done_o: no mismatch, KAT ok, no timeout
- kat_fail_o  output  1  KAT mismatch seen
- timeout_o  output  1  run aborted by timeout
- fail_cnt_o  output  16  round-trip mismatches, saturating at 16'hFFFF
- fail_idx_o  output  16  index of first mismatching vector; 16'hFFFF if none
- vec_cnt_o  output  16  vectors completed

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0 except fail_idx_o=16'hFFFF. LFSR=SEED, timer=0.
- States: IDLE, LOAD, WAIT_ENC, WAIT_DEC, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR with start=1 -> LOAD. Clears done_o, pass_o, kat_fail_o, timeout_o, fail_cnt_o, vec_cnt_o. Sets fail_idx_o=16'hFFFF, LFSR=SEED, busy_o=1.
- LOAD, one cycle:
  - enc_data_o = LFSR; the value is held stable until the next LOAD.
  - enc_en_o=1 for exactly this cycle. Go to WAIT_ENC.
- WAIT_ENC: on the first cycle enc_ready_i=1, capture enc_data_i and go to WAIT_DEC.
  - KAT check, only when KAT_EN and vector 0: if the captured value != KAT_CT, set kat_fail_o.
- WAIT_DEC: on the first cycle dec_ready_i=1, capture dec_data_i and go to CHECK.
  - If enc_ready_i and dec_ready_i are both high on the same cycle in WAIT_ENC, only enc is taken. dec is sampled from the next cycle.
- CHECK, one cycle:
  - If captured dec != enc_data_o: increment fail_cnt_o (saturating). If fail_idx_o==16'hFFFF, set fail_idx_o=vec_cnt_o.
  - Increment vec_cnt_o and advance the LFSR one step.
  - If vec_cnt_o+1==NVEC -> DONE, else -> LOAD.
- LFSR: 128-bit Galois, polynomial x^128+x^7+x^2+x+1, shift left. If the MSB shifted out is 1, XOR 128'h87 into the result.
- Timer:
  - Resets to 0 on entry to WAIT_ENC and to WAIT_DEC, and increments each cycle in those states.
  - When timer==TIMEOUT-1 and the awaited ready is still low -> ERROR with timeout_o=1.
- DONE: busy_o=0, done_o=1, pass_o = (fail_cnt_o==0) & !kat_fail_o.
- ERROR: busy_o=0, done_o=1, pass_o=0.
- start while busy_o=1 is ignored.
- rst mid-run aborts immediately to the reset state. No partial results are kept.

Decomposition:
- aes_const gains: BIST_LFSR_POLY (128'h87), BIST_IDX_NONE (16'hFFFF), and typedef bist_state_t (enum of the seven states).
- One sub-module: aes_bist_lfsr, combinational next-state function of the 128-bit Galois step. This lets the bench reuse it for the expected plaintext sequence.

Test Plan:
1. Reset with start=0 -> after 10 cycles: busy_o=0, done_o=0, pass_o=0, fail_idx_o=16'hFFFF, enc_en_o=0.
2. Key 000102..0f, real cipher/icipher chained, NVEC=4, start pulse:
   - enc_data_o=SEED in the first LOAD.
   - Captured ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
   - done_o=1, pass_o=1, vec_cnt_o=4, fail_cnt_o=0, fail_idx_o=16'hFFFF.
3. Same run with dec_data_i bit 0 flipped during vector 2 only -> fail_cnt_o=1, fail_idx_o=2, pass_o=0, vec_cnt_o=4.
4. Key 0 (wrong for KAT_CT) -> kat_fail_o=1, fail_cnt_o=0, pass_o=0 at done_o.
5. enc_ready_i tied 0, TIMEOUT=16 -> ERROR exactly 16 cycles after entering WAIT_ENC: timeout_o=1, done_o=1, busy_o=0. A second start restarts cleanly.
6. rst asserted during vector 1 WAIT_DEC -> outputs return to reset values asynchronously. A later start begins again at enc_data_o=SEED. A start asserted while busy_o=1 does not restart the run.
